i2c_slave_ctrl: RTL

- I2C target (slave) controller: the responder on the same SCL/SDA bus that the team's I2C master bit controller drives.
- Detects START/STOP, receives and matches a 7-bit address, and ACKs master writes byte by byte to a local byte interface.
- Supplies read bytes from a local request/acknowledge interface, stretching SCL low until each byte is provided.
- Sits between the open-drain pad logic (active-low output enables) and a register-file or FIFO client.

---
 rtl/i2c_slave_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: filtered START/STOP detection, 7-bit address match,
// byte writes to a local client and clock-stretched byte reads from it.
module i2c_slave_ctrl #(
  parameter int FILT_LEN = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ena,
  input  logic [6:0] slv_addr,
  input  logic       scl_i,
  output logic       scl_oen,
  input  logic       sda_i,
  output logic       sda_oen,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_full,
  output logic       tx_req,
  input  logic       tx_ack,
  input  logic [7:0] tx_data,
  output logic       addressed,
  output logic       rw,
  output logic       busy,
  output logic [3:0] state_dbg
);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_ADDR = 4'd1, S_ADDR_ACK = 4'd2, S_WR_DATA = 4'd3, S_WR_ACK = 4'd4,
    S_RD_LOAD = 4'd5, S_RD_DATA = 4'd6, S_RD_ACK = 4'd7, S_IGNORE = 4'd8
  } state_t;

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [3:0] LAST_BIT = 4'd7;

  logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic       r_scl_f, r_sda_f, r_scl_d, r_sda_d;
  logic [3:0] r_scl_cnt, r_sda_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1;
      r_scl_f  <= 1'b1; r_sda_f  <= 1'b1; r_scl_d  <= 1'b1; r_sda_d  <= 1'b1;
      r_scl_cnt <= 4'd0; r_sda_cnt <= 4'd0;
    end else begin
      r_scl_s1 <= scl_i;    r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_i;    r_sda_s2 <= r_sda_s1;
      r_scl_d  <= r_scl_f;  r_sda_d  <= r_sda_f;
      // A level change needs FILT_LEN consecutive differing samples
      if (r_scl_s2 == r_scl_f) r_scl_cnt <= 4'd0;
      else if (r_scl_cnt == FILT_MAX) begin r_scl_f <= r_scl_s2; r_scl_cnt <= 4'd0; end
      else r_scl_cnt <= r_scl_cnt + 4'd1;
      if (r_sda_s2 == r_sda_f) r_sda_cnt <= 4'd0;
      else if (r_sda_cnt == FILT_MAX) begin r_sda_f <= r_sda_s2; r_sda_cnt <= 4'd0; end
      else r_sda_cnt <= r_sda_cnt + 4'd1;
    end
  end

  logic w_rise, w_fall, w_start, w_stop, w_match;
  logic [7:0] w_shift_in;
  assign w_rise = r_scl_f & ~r_scl_d;
  assign w_fall = ~r_scl_f & r_scl_d;
  // SDA moving together with an SCL rise (read data released with the stretch) is not a bus condition
  assign w_start = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
  assign w_stop  = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_shift, w_shift, r_rx_data, w_rx_data;
  logic       r_phase, w_phase, r_nack, w_nack;
  logic       r_scl_oen, w_scl_oen, r_sda_oen, w_sda_oen;
  logic       r_rx_valid, w_rx_valid, r_tx_req, w_tx_req;
  logic       r_addressed, w_addressed, r_rw, w_rw, r_busy, w_busy;

  assign w_shift_in = {r_shift[6:0], r_sda_f};
  assign w_match    = (r_shift[6:0] == slv_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE; r_cnt <= 4'd0; r_shift <= 8'd0; r_rx_data <= 8'd0;
      r_phase <= 1'b0; r_nack <= 1'b0; r_scl_oen <= 1'b1; r_sda_oen <= 1'b1;
      r_rx_valid <= 1'b0; r_tx_req <= 1'b0; r_addressed <= 1'b0; r_rw <= 1'b0; r_busy <= 1'b0;
    end else begin
      r_state <= w_state_nxt; r_cnt <= w_cnt; r_shift <= w_shift; r_rx_data <= w_rx_data;
      r_phase <= w_phase; r_nack <= w_nack; r_scl_oen <= w_scl_oen; r_sda_oen <= w_sda_oen;
      r_rx_valid <= w_rx_valid; r_tx_req <= w_tx_req; r_addressed <= w_addressed;
      r_rw <= w_rw; r_busy <= w_busy;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!ena || w_stop) w_state_nxt = S_IDLE;
    else if (w_start) w_state_nxt = S_ADDR;
    else begin
      case (r_state)
        S_ADDR:     if (w_rise && r_cnt == LAST_BIT) w_state_nxt = w_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (w_fall && r_phase) w_state_nxt = r_rw ? S_RD_LOAD : S_WR_DATA;
        S_WR_DATA:  if (w_rise && r_cnt == LAST_BIT) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   if (w_fall && r_phase) w_state_nxt = r_nack ? S_IGNORE : S_WR_DATA;
        S_RD_LOAD:  if (tx_ack) w_state_nxt = S_RD_DATA;
        S_RD_DATA:  if (w_fall && r_cnt == LAST_BIT) w_state_nxt = S_RD_ACK;
        S_RD_ACK: begin
          if (w_rise && r_sda_f) w_state_nxt = S_IGNORE;
          else if (w_fall && r_phase) w_state_nxt = S_RD_LOAD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cnt = r_cnt; w_shift = r_shift; w_rx_data = r_rx_data; w_phase = r_phase; w_nack = r_nack;
    w_scl_oen = r_scl_oen; w_sda_oen = r_sda_oen; w_rx_valid = 1'b0; w_tx_req = 1'b0;
    w_addressed = r_addressed; w_rw = r_rw; w_busy = r_busy;
    if (!ena || w_stop) begin
      w_scl_oen = 1'b1; w_sda_oen = 1'b1; w_addressed = 1'b0; w_busy = 1'b0; w_cnt = 4'd0;
    end else if (w_start) begin
      w_scl_oen = 1'b1; w_sda_oen = 1'b1; w_addressed = 1'b0; w_busy = 1'b1;
      w_cnt = 4'd0; w_phase = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: if (w_rise) begin
          w_shift = w_shift_in;
          w_cnt   = r_cnt + 4'd1;
          if (r_cnt == LAST_BIT) begin
            w_cnt = 4'd0; w_phase = 1'b0;
            if (w_match) w_rw = r_sda_f;
          end
        end
        S_ADDR_ACK: if (w_fall) begin
          if (!r_phase) begin
            w_sda_oen = 1'b0; w_addressed = 1'b1; w_phase = 1'b1;
          end else begin
            w_sda_oen = 1'b1;
            if (r_rw) begin w_scl_oen = 1'b0; w_tx_req = 1'b1; end
          end
        end
        S_WR_DATA: if (w_rise) begin
          w_shift = w_shift_in;
          w_cnt   = r_cnt + 4'd1;
          if (r_cnt == LAST_BIT) begin
            w_cnt = 4'd0; w_phase = 1'b0; w_nack = rx_full;
            if (!rx_full) begin w_rx_data = w_shift_in; w_rx_valid = 1'b1; end
          end
        end
        S_WR_ACK: if (w_fall) begin
          if (!r_phase) begin
            w_sda_oen = r_nack; w_phase = 1'b1;
          end else begin
            w_sda_oen = 1'b1;
            if (r_nack) w_addressed = 1'b0;
          end
        end
        S_RD_LOAD: if (tx_ack) begin
          w_shift = tx_data; w_sda_oen = tx_data[7]; w_scl_oen = 1'b1; w_cnt = 4'd0;
        end
        S_RD_DATA: if (w_fall) begin
          if (r_cnt == LAST_BIT) begin
            w_sda_oen = 1'b1; w_cnt = 4'd0; w_phase = 1'b0;
          end else begin
            w_sda_oen = r_shift[6]; w_shift = {r_shift[6:0], 1'b0}; w_cnt = r_cnt + 4'd1;
          end
        end
        S_RD_ACK: begin
          if (w_rise) begin
            if (r_sda_f) w_addressed = 1'b0;
            else w_phase = 1'b1;
          end else if (w_fall && r_phase) begin
            w_scl_oen = 1'b0; w_sda_oen = 1'b1; w_tx_req = 1'b1;
          end
        end
        default: begin
          w_scl_oen = 1'b1; w_sda_oen = 1'b1;
        end
      endcase
    end
  end

  assign scl_oen   = r_scl_oen;
  assign sda_oen   = r_sda_oen;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_req    = r_tx_req;
  assign addressed = r_addressed;
  assign rw        = r_rw;
  assign busy      = r_busy;
  assign state_dbg = r_state;
endmodule
